// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmitter and receiver: the transmit
//   state encoding plus the frame and baud-rate constants both sides agree on.
package uart_pkg;

  localparam int UART_DATA_BITS             = 8;
  localparam int UART_DEFAULT_CLKS_PER_BAUD = 1250;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period timer. Counts 0..CLKS_PER_BAUD-1 and flags the terminal count,
//   after which it restarts from zero. Holding clear keeps the count at zero so
//   the first bit of a frame always gets a full period.
//
// Ports:
//   clk    in   system clock
//   nRst   in   asynchronous active-low reset
//   clear  in   hold counter at zero (e.g. while the line is idle)
//   tick   out  high for the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = UART_DEFAULT_CLKS_PER_BAUD
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = !clear && (cnt_q == TERMINAL);
    cnt_d = cnt_q + CNT_W'(1);
    // Wrapping at the terminal count keeps the counter from ever exceeding it.
    if (clear || (cnt_q == TERMINAL)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   UART transmitter: 1 start bit, 8 data bits LSB first, even parity, 1 stop
//   bit. Bytes arrive over a valid/ready handshake and leave on tx_serial.
//
// Ports:
//   clk        in   system clock
//   nRst       in   asynchronous active-low reset
//   tx_valid   in   producer has a byte on tx_byte
//   tx_byte    in   byte to send, sampled only on the accept cycle
//   tx_ready   out  transmitter can accept a byte this cycle (IDLE only)
//   tx_serial  out  serial line, idle high, registered
//   tx_busy    out  frame in progress
//   tx_done    out  one-cycle pulse after the stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = UART_DEFAULT_CLKS_PER_BAUD
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  output logic                      tx_ready,
  output logic                      tx_serial,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      serial_q, serial_d;
  logic                      done_q, done_d;
  logic                      accept;
  logic                      baud_clear;
  logic                      tick;

  assign tx_ready   = (state_q == IDLE);
  assign tx_busy    = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
  assign tx_serial  = serial_q;
  assign tx_done    = done_q;
  assign accept     = tx_valid && tx_ready;
  // Any non-frame state (including an illegal encoding) parks the timer at
  // zero, so a freshly accepted byte always starts a whole start-bit period.
  assign baud_clear = !tx_busy;

  uart_baud_gen #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_baud_gen (
    .clk  (clk),
    .nRst (nRst),
    .clear(baud_clear),
    .tick (tick)
  );

  // serial_d is derived from the current state and registered, so the line
  // trails the state by one cycle: the start bit appears on the edge after
  // the accept edge and the line stays high for one cycle after STOP ends.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    serial_d  = 1'b1;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        if (accept) begin
          shift_d  = tx_byte;
          parity_d = ^tx_byte;
          state_d  = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        serial_d = shift_q[bit_idx_q];
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        serial_d = parity_q;
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        shift_d   = '0;
        parity_d  = 1'b0;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Directed bench for uart_tx. A fast instance (4 clocks per bit) covers
//   framing, parity, handshake and reset; a default-rate instance is decoded by
//   a simple bit-centre sampling receiver for the loopback case.
module tb_uart_tx;

  logic       clk;
  logic       nRst;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  logic       s_valid;
  logic [7:0] s_byte;
  logic       s_ready;
  logic       s_serial;
  logic       s_busy;
  logic       s_done;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLKS_PER_BAUD(4)
  ) u_dut (
    .clk      (clk),
    .nRst     (nRst),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx #(
    .CLKS_PER_BAUD(1250)
  ) u_dut_slow (
    .clk      (clk),
    .nRst     (nRst),
    .tx_valid (s_valid),
    .tx_byte  (s_byte),
    .tx_ready (s_ready),
    .tx_serial(s_serial),
    .tx_busy  (s_busy),
    .tx_done  (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a byte at a negedge and return just after the accept edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    checkOutput("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(posedge clk);
  endtask

  // Watch the 45 cycles after an accept edge. Window w is the half-period after
  // edge w; bit k occupies windows 4k+1..4k+4 and is sampled at 4k+3.
  // mode 0: drop valid; mode 1: keep valid with aux as next byte;
  // mode 2: drop valid, then pulse valid with aux mid-frame.
  task automatic monitor_frame(input logic [7:0] b, input logic par,
                               input int mode, input logic [7:0] aux);
    logic line [0:44];
    logic exp_bit;
    int   busy_cnt;
    int   done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    for (int w = 0; w <= 44; w++) begin
      @(negedge clk);
      line[w] = tx_serial;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) done_cnt++;
      if (w == 0) begin
        if (mode == 1) tx_byte = aux;
        else tx_valid = 1'b0;
      end
      if (mode == 2 && w == 10) begin
        checkOutput("busy_ready_low", tx_ready, 0);
        tx_valid = 1'b1;
        tx_byte  = aux;
      end
      if (mode == 2 && w == 11) begin
        tx_valid = 1'b0;
      end
    end
    checkOutput($sformatf("%02h_idle_lead", b), line[0], 1);
    checkOutput($sformatf("%02h_start_edge", b), line[1], 0);
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) exp_bit = 1'b0;
      else if (k <= 8) exp_bit = b[k-1];
      else if (k == 9) exp_bit = par;
      else exp_bit = 1'b1;
      checkOutput($sformatf("%02h_bit%0d", b, k), line[4*k+3], exp_bit);
    end
    checkOutput($sformatf("%02h_busy_cycles", b), busy_cnt, 44);
    checkOutput($sformatf("%02h_done_count", b), done_cnt, 1);
    checkOutput($sformatf("%02h_done_end", b), tx_done, 1);
    checkOutput($sformatf("%02h_ready_end", b), tx_ready, 1);
    checkOutput($sformatf("%02h_line_end", b), tx_serial, 1);
  endtask

  initial begin : stimulus
    logic [7:0] rx_byte;
    logic       rx_start;
    logic       rx_par;
    logic       rx_stop;
    int         guard;
    int         bad_cnt;

    nRst     = 1'b1;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    s_valid  = 1'b0;
    s_byte   = 8'h00;
    #1 nRst  = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_serial", tx_serial, 1);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single frames");
    applyStimulus(8'hA5);
    monitor_frame(8'hA5, 1'b0, 0, 8'h00);
    applyStimulus(8'h07);
    monitor_frame(8'h07, 1'b1, 0, 8'h00);
    applyStimulus(8'h00);
    monitor_frame(8'h00, 1'b0, 0, 8'h00);
    applyStimulus(8'hFF);
    monitor_frame(8'hFF, 1'b0, 0, 8'h00);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h41);
    monitor_frame(8'h41, 1'b0, 1, 8'h42);
    @(posedge clk);
    monitor_frame(8'h42, 1'b0, 0, 8'h00);

    $display("[TB] request while busy");
    applyStimulus(8'h5A);
    monitor_frame(8'h5A, 1'b0, 2, 8'h33);
    bad_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_serial !== 1'b1) bad_cnt++;
    end
    checkOutput("ignored_no_frame", bad_cnt, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    checkOutput("mid_data_line_low", tx_serial, 0);
    checkOutput("mid_data_busy", tx_busy, 1);
    #2 nRst = 1'b0;
    #1;
    checkOutput("async_rst_serial", tx_serial, 1);
    checkOutput("async_rst_ready", tx_ready, 1);
    checkOutput("async_rst_busy", tx_busy, 0);
    checkOutput("async_rst_done", tx_done, 0);
    @(negedge clk);
    nRst = 1'b1;
    bad_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_serial !== 1'b1) bad_cnt++;
    end
    checkOutput("post_rst_quiet", bad_cnt, 0);

    $display("[TB] loopback at 1250 clocks per bit");
    @(negedge clk);
    s_valid = 1'b1;
    s_byte  = 8'h48;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_byte  = 8'hC3;
    guard = 0;
    while (s_serial !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("lb_start_seen", (guard < 5000), 1);
    repeat (625) @(negedge clk);
    rx_start = s_serial;
    for (int i = 0; i < 8; i++) begin
      repeat (1250) @(negedge clk);
      rx_byte[i] = s_serial;
    end
    repeat (1250) @(negedge clk);
    rx_par = s_serial;
    repeat (1250) @(negedge clk);
    rx_stop = s_serial;
    checkOutput("lb_start_bit", rx_start, 0);
    checkOutput("lb_rx_byte", rx_byte, 8'h48);
    checkOutput("lb_parity_bit", rx_par, 0);
    checkOutput("lb_parity_err", (^{rx_byte, rx_par}), 0);
    checkOutput("lb_rx_ready", rx_stop, 1);
    guard = 0;
    while (s_done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("lb_done_seen", (guard < 2000), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
